// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light display path: light-state bit positions,
// seven-segment codes (active-low {g,f,e,d,c,b,a}) and small decode helpers.
package traffic_pkg;

   // Bit positions inside a 3-bit gry light-state word
   localparam int unsigned GRY_G = 2;
   localparam int unsigned GRY_R = 1;
   localparam int unsigned GRY_Y = 0;

   // Seven-segment codes, active-low, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_G     = 7'b1000010;
   localparam logic [6:0] SEG_R     = 7'b0101111;
   localparam logic [6:0] SEG_Y     = 7'b0010001;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Sequential BCD converter states
   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } conv_state_e;

   // Decimal digit to segment code; non-decimal codes show blank
   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   // Light state to letter; anything that is not exactly one lamp shows a dash
   function automatic logic [6:0] gry_to_seg(input logic [2:0] gry);
      logic [2:0] only_g;
      logic [2:0] only_r;
      logic [2:0] only_y;
      logic [6:0] code;
      only_g        = 3'b000;
      only_r        = 3'b000;
      only_y        = 3'b000;
      only_g[GRY_G] = 1'b1;
      only_r[GRY_R] = 1'b1;
      only_y[GRY_Y] = 1'b1;
      if (gry == only_g) begin
         code = SEG_G;
      end else if (gry == only_r) begin
         code = SEG_R;
      end else if (gry == only_y) begin
         code = SEG_Y;
      end else begin
         code = SEG_DASH;
      end
      return code;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to two-digit BCD converter.
// One shift per cycle; busy for exactly COUNT_BITS cycles, then a one-cycle done
// pulse while tens/ones hold the result. The result stays valid until the next start.
module bin2bcd_seq
   import traffic_pkg::*;
#(
   parameter int unsigned COUNT_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [COUNT_BITS-1:0] bin,
   output logic                  busy,
   output logic                  done,
   output logic [3:0]            tens,
   output logic [3:0]            ones
);

   // Working register: {tens, ones, binary remainder}
   localparam int unsigned SW       = COUNT_BITS + 8;
   localparam logic [2:0]  CNT_INIT = 3'(COUNT_BITS);

   conv_state_e   r_state;
   conv_state_e   w_state_nx;
   logic [SW-1:0] r_shift;
   logic [SW-1:0] w_shift_nx;
   logic [SW-1:0] w_adj;
   logic [2:0]    r_cnt;
   logic [2:0]    w_cnt_nx;

   // Add 3 to any BCD nibble that is 5 or more, ahead of the left shift
   always_comb begin
      w_adj = r_shift;
      if (r_shift[COUNT_BITS +: 4] >= 4'd5) begin
         w_adj[COUNT_BITS +: 4] = r_shift[COUNT_BITS +: 4] + 4'd3;
      end
      if (r_shift[COUNT_BITS + 4 +: 4] >= 4'd5) begin
         w_adj[COUNT_BITS + 4 +: 4] = r_shift[COUNT_BITS + 4 +: 4] + 4'd3;
      end
   end

   // Next-state: load on start, shift COUNT_BITS times, flag done for one cycle
   always_comb begin
      w_state_nx = r_state;
      w_shift_nx = r_shift;
      w_cnt_nx   = r_cnt;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nx = StShift;
               w_shift_nx = {8'd0, bin};
               w_cnt_nx   = CNT_INIT;
            end
         end
         StShift: begin
            w_shift_nx = {w_adj[SW-2:0], 1'b0};
            w_cnt_nx   = r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
               w_state_nx = StDone;
            end
         end
         StDone: begin
            w_state_nx = StIdle;
         end
         default: begin
            w_state_nx = StIdle;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_shift <= '0;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_state_nx;
         r_shift <= w_shift_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign busy = (r_state == StShift);
   assign done = (r_state == StDone);
   assign tens = r_shift[SW-1 -: 4];
   assign ones = r_shift[SW-5 -: 4];

endmodule

// File: rtl/countdown_display.sv
// Four-digit multiplexed seven-segment driver for the traffic controller:
// digit 0/1 show the remaining seconds (ones, blank-suppressed tens), digit 2/3 show the
// highway and country light letters. The count is converted to BCD by bin2bcd_seq
// whenever it differs from the last captured value.
module countdown_display
   import traffic_pkg::*;
#(
   parameter int unsigned COUNT_BITS = 4,
   parameter int unsigned SCAN_DIV   = 100_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [COUNT_BITS-1:0] current_count,
   input  logic [2:0]            highway_gry,
   input  logic [2:0]            country_gry,
   output logic [6:0]            seg,
   output logic [3:0]            an
);

   localparam int unsigned    PW        = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

   // Capture / conversion
   logic [COUNT_BITS-1:0] r_cap;
   logic                  r_valid;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_idle;
   logic                  w_start;
   logic [3:0]            w_tens;
   logic [3:0]            w_ones;
   logic [6:0]            r_ones_seg;
   logic [6:0]            r_tens_seg;
   logic [6:0]            w_ones_seg_nx;
   logic [6:0]            w_tens_seg_nx;

   // Scan
   logic                  r_scan_on;
   logic [PW-1:0]         r_presc;
   logic [PW-1:0]         w_presc_nx;
   logic [1:0]            r_idx;
   logic [1:0]            w_idx_nx;
   logic [6:0]            w_seg_nx;
   logic [3:0]            w_an_nx;

   // The done cycle is not idle: valid only sets on that edge, so starting there would
   // launch a spurious reconversion of the value just finished.
   assign w_idle  = !w_busy && !w_done;
   assign w_start = w_idle && (!r_valid || (current_count != r_cap));

   bin2bcd_seq #(
      .COUNT_BITS (COUNT_BITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .bin   (current_count),
      .busy  (w_busy),
      .done  (w_done),
      .tens  (w_tens),
      .ones  (w_ones)
   );

   // Next digit codes: ones/tens change together only when a conversion finishes
   always_comb begin
      w_ones_seg_nx = r_ones_seg;
      w_tens_seg_nx = r_tens_seg;
      if (w_done) begin
         w_ones_seg_nx = digit_to_seg(w_ones);
         w_tens_seg_nx = (w_tens == 4'd0) ? SEG_BLANK : digit_to_seg(w_tens);
      end
   end

   // Capture the count on conversion start; hold digit codes and the valid flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cap      <= '0;
         r_valid    <= 1'b0;
         r_ones_seg <= SEG_BLANK;
         r_tens_seg <= SEG_BLANK;
      end else begin
         if (w_start) begin
            r_cap <= current_count;
         end
         if (w_done) begin
            r_valid <= 1'b1;
         end
         r_ones_seg <= w_ones_seg_nx;
         r_tens_seg <= w_tens_seg_nx;
      end
   end

   // Prescaler/index next-state. The first edge out of reset only turns the display on,
   // so digit 0 gets the full SCAN_DIV cycles like every later digit.
   always_comb begin
      w_presc_nx = r_presc;
      w_idx_nx   = r_idx;
      if (r_scan_on) begin
         if (r_presc == PRESC_MAX) begin
            w_presc_nx = '0;
            w_idx_nx   = r_idx + 2'd1;
         end else begin
            w_presc_nx = r_presc + PW'(1);
         end
      end
   end

   // Segment/anode selection from the next index so an and seg move on the same edge
   always_comb begin
      w_seg_nx = SEG_BLANK;
      case (w_idx_nx)
         2'd0:    w_seg_nx = w_ones_seg_nx;
         2'd1:    w_seg_nx = w_tens_seg_nx;
         2'd2:    w_seg_nx = gry_to_seg(highway_gry);
         2'd3:    w_seg_nx = gry_to_seg(country_gry);
         default: w_seg_nx = SEG_BLANK;
      endcase
      w_an_nx           = 4'b1111;
      w_an_nx[w_idx_nx] = 1'b0;
   end

   // Scan state and registered display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_on <= 1'b0;
         r_presc   <= '0;
         r_idx     <= 2'd0;
         seg       <= SEG_BLANK;
         an        <= 4'b1111;
      end else begin
         r_scan_on <= 1'b1;
         r_presc   <= w_presc_nx;
         r_idx     <= w_idx_nx;
         seg       <= w_seg_nx;
         an        <= w_an_nx;
      end
   end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter COUNT_BITS, 4, width of current_count; legal range 1..6 (max 63, two digits).
REQ-002 Parameter SCAN_DIV, 100_000, clock cycles each digit stays enabled; legal minimum 2.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port current_count  input  COUNT_BITS  remaining seconds from the countdown controller, unsigned.
REQ-006 Port highway_gry  input  3  highway light state; bit2 green, bit1 red, bit0 yellow.
REQ-007 Port country_gry  input  3  country light state; same encoding as highway_gry.
REQ-008 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 Port an  output  4  digit enables, active-low one-hot, registered.

Function
REQ-010 Digit map SHALL be: an[0] count ones, an[1] count tens, an[2] highway letter, an[3] country letter.
REQ-011 Codes SHALL be: '0' 1000000, '1' 1111001, '2' 0100100, '3' 0110000, '4' 0011001, '5' 0010010, '6' 0000010, '7' 1111000, '8' 0000000, '9' 0010000, blank 1111111, 'G' 1000010, 'r' 0101111, 'Y' 0010001, '-' 0111111.
REQ-012 Letter digits SHALL show 'G', 'r' or 'Y' for gry 100, 010, 001; any non-one-hot value SHALL show '-'.
REQ-013 Letter digits SHALL be decoded from inputs sampled on the clock edge that loads seg; they are not buffered.
REQ-014 Conversion SHALL use a sequential shift-add-3 (double-dabble) converter, one shift per cycle.
REQ-015 The block SHALL hold a captured copy of current_count and a valid flag.
REQ-016 Start condition: converter idle and (valid=0 or current_count != captured); captured SHALL load on that edge.
REQ-017 Busy duration SHALL be COUNT_BITS cycles after start.
REQ-018 Ones/tens display registers SHALL update together on the cycle after the last shift; total latency from input change to new digits = COUNT_BITS+2 cycles; valid set then.
REQ-019 A change of current_count while busy SHALL NOT abort the conversion; on return to idle the mismatch SHALL trigger a new conversion; the final displayed value SHALL equal the final stable input.
REQ-020 Leading-zero blanking: tens digit SHALL show blank when tens=0; ones digit always shows a numeral.
REQ-021 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance 0,1,2,3,0.
REQ-022 an SHALL drive 0 only at bit [index]; seg SHALL update on the same edge as an, with no cycle of mismatch.
REQ-023 Each digit SHALL be enabled exactly SCAN_DIV consecutive cycles; full frame = 4*SCAN_DIV cycles.
REQ-024 Before the first conversion completes (valid=0) ones and tens SHALL show blank.

Reset
REQ-025 While rst=1 on an edge: an=1111, seg=1111111, prescaler=0, index=0, valid=0, converter idle, digit registers blank.
REQ-026 First edge with rst=0 SHALL start a conversion (valid=0) and enable an[0] with blank seg.
REQ-027 rst asserted mid-conversion or mid-scan SHALL override everything, with no partial update committed.

Structure
REQ-028 Shared package traffic_pkg SHALL hold gry bit indices (GRY_G=2, GRY_R=1, GRY_Y=0) and all seven-segment code constants of REQ-011.
REQ-029 Converter SHALL be sub-module bin2bcd_seq (ports clk, rst, start, bin, busy, done, tens, ones); top contains the prescaler, index, capture and segment mux.

Verification
REQ-030 rst 5 cycles, inputs 0 -> an=1111/seg=1111111 during reset; an[0] low with blank seg first cycle after; digits "0" and blank tens after 6 cycles.
REQ-031 COUNT_BITS=4, count 13, highway_gry=100, country_gry=010, SCAN_DIV=4 -> over one 16-cycle frame see 0110000, 1111001, 1000010, 0101111 on an 1110, 1101, 1011, 0111.
REQ-032 count 13 -> 5 -> after 6 cycles ones 0010010, tens blank 1111111.
REQ-033 highway_gry=110, country_gry=000 -> both letter digits 0111111.
REQ-034 count 9 changed to 12 two cycles after start of conversion of 9 -> 9 shown briefly then 12 within 12 cycles of the change; never any other value.
REQ-035 rst pulsed mid-frame on index 2 -> next edge an=1111; after release the scan restarts at index 0 and the digits re-convert.
